// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, FSM states and helpers for the SPI command decoder.
// Imported by the decoder top and its testbench-facing parameters.
package spi_cmd_pkg;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_SET_DIGIT = 8'h10;
    localparam logic [7:0] OP_SET_ALL   = 8'h20;
    localparam logic [7:0] OP_SET_COLON = 8'h30;
    localparam logic [7:0] OP_READ      = 8'h40;

    localparam logic [7:0] ACK_DEFAULT = 8'hA5;
    localparam logic [7:0] NAK_DEFAULT = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARG1  = 2'd1,
        ST_ARG2  = 2'd2,
        ST_RD_HI = 2'd3
    } state_e;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

endpackage

// File: rtl/byte_strobe.sv
// Rising-edge detector for a level-valid source.
// Emits one pulse per low-to-high transition of the level.
module byte_strobe (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic pulse
);

    logic rx_q;
    logic rx_d;

    // Previous level follows the input every cycle.
    always_comb begin
        rx_d = level;
    end

    // Previous-level register, cleared on reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_q <= 1'b0;
        end else begin
            rx_q <= rx_d;
        end
    end

    assign pulse = level & ~rx_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes framed SPI commands into 7-seg digits/colon and a reply byte.
// One reply strobe per received byte keeps the SPI stream byte-aligned.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 32000,
    parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_ready,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx,
    output logic       tx_ready,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [1:0] colon,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic strb;

    state_e      state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  arg1_q, arg1_d;
    logic [15:0] digits_q, digits_d;
    logic [1:0]  colon_q, colon_d;
    logic [7:0]  tx_q, tx_d;
    logic        tx_ready_q, tx_ready_d;
    logic        frame_err_q, frame_err_d;

    logic is_nop;
    logic is_arg_op;
    logic is_read;
    logic all_bcd;

    byte_strobe u_strobe (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (rx_ready),
        .pulse   (strb)
    );

    assign is_nop    = (rx_byte == OP_NOP);
    assign is_read   = (rx_byte == OP_READ);
    assign is_arg_op = (rx_byte[7:2] == OP_SET_DIGIT[7:2])
                     | (rx_byte == OP_SET_ALL)
                     | (rx_byte == OP_SET_COLON);
    assign all_bcd   = is_bcd(arg1_q[7:4]) & is_bcd(arg1_q[3:0])
                     & is_bcd(rx_byte[7:4]) & is_bcd(rx_byte[3:0]);

    // Next-state, datapath updates and reply generation.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        op_d        = op_q;
        arg1_d      = arg1_q;
        digits_d    = digits_q;
        colon_d     = colon_q;
        tx_d        = tx_q;
        tx_ready_d  = 1'b0;
        frame_err_d = 1'b0;

        if (strb) begin
            timer_d    = '0;
            tx_ready_d = 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    unique case (1'b1)
                        is_nop: begin
                            tx_d = ACK_BYTE;
                        end
                        is_arg_op: begin
                            op_d    = rx_byte;
                            state_d = ST_ARG1;
                            tx_d    = ACK_BYTE;
                        end
                        is_read: begin
                            state_d = ST_RD_HI;
                            tx_d    = digits_q[7:0];
                        end
                        default: begin
                            tx_d        = NAK_BYTE;
                            frame_err_d = 1'b1;
                        end
                    endcase
                end
                ST_ARG1: begin
                    state_d = ST_IDLE;
                    unique case (1'b1)
                        (op_q == OP_SET_ALL): begin
                            arg1_d  = rx_byte;
                            state_d = ST_ARG2;
                            tx_d    = ACK_BYTE;
                        end
                        (op_q == OP_SET_COLON): begin
                            colon_d = rx_byte[1:0];
                            tx_d    = ACK_BYTE;
                        end
                        default: begin
                            if (is_bcd(rx_byte[3:0])) begin
                                digits_d[{op_q[1:0], 2'b00} +: 4] = rx_byte[3:0];
                                tx_d = ACK_BYTE;
                            end else begin
                                tx_d        = NAK_BYTE;
                                frame_err_d = 1'b1;
                            end
                        end
                    endcase
                end
                ST_ARG2: begin
                    state_d = ST_IDLE;
                    if (all_bcd) begin
                        digits_d = {arg1_q, rx_byte};
                        tx_d     = ACK_BYTE;
                    end else begin
                        tx_d        = NAK_BYTE;
                        frame_err_d = 1'b1;
                    end
                end
                ST_RD_HI: begin
                    state_d = ST_IDLE;
                    tx_d    = digits_q[15:8];
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (timer_q == T_LAST) begin
                state_d     = ST_IDLE;
                timer_d     = '0;
                frame_err_d = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            op_q        <= 8'h00;
            arg1_q      <= 8'h00;
            digits_q    <= 16'h0000;
            colon_q     <= 2'b11;
            tx_q        <= 8'h00;
            tx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            op_q        <= op_d;
            arg1_q      <= arg1_d;
            digits_q    <= digits_d;
            colon_q     <= colon_d;
            tx_q        <= tx_d;
            tx_ready_q  <= tx_ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign tx        = tx_q;
    assign tx_ready  = tx_ready_q;
    assign frame_err = frame_err_q;
    assign digit0    = digits_q[3:0];
    assign digit1    = digits_q[7:4];
    assign digit2    = digits_q[11:8];
    assign digit3    = digits_q[15:12];
    assign colon     = colon_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed frames plus random
// byte streams compared against a frame-level reference model.
module tb_spi_cmd_decoder;

    localparam int T = 100;
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'h5A;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx;
    logic       tx_ready;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [1:0] colon;
    logic       frame_err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int strobe_cyc = 0;

    logic [3:0] md [4];
    logic [1:0] mcol;
    logic [7:0] frm [$];

    spi_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_ready  (rx_ready),
        .rx_byte   (rx_byte),
        .tx        (tx),
        .tx_ready  (tx_ready),
        .digit0    (digit0),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .colon     (colon),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) md[i] = 4'd0;
        mcol = 2'b11;
        frm.delete();
    endtask

    // Frame-level reference: collects bytes of a frame and acts once
    // the frame is complete, returning the expected reply for this byte.
    task automatic model_byte(input logic [7:0] b,
                              output logic [7:0] rep, output logic err);
        logic [7:0] op, a, c;
        rep = ACK;
        err = 1'b0;
        frm.push_back(b);
        op = frm[0];
        if (op == 8'h40) begin
            if (frm.size() == 1) rep = {md[1], md[0]};
            else begin
                rep = {md[3], md[2]};
                frm.delete();
            end
        end else if (op == 8'h00) begin
            frm.delete();
        end else if (op >= 8'h10 && op <= 8'h13) begin
            if (frm.size() == 2) begin
                if (b[3:0] <= 4'd9) md[op[1:0]] = b[3:0];
                else begin rep = NAK; err = 1'b1; end
                frm.delete();
            end
        end else if (op == 8'h30) begin
            if (frm.size() == 2) begin
                mcol = b[1:0];
                frm.delete();
            end
        end else if (op == 8'h20) begin
            if (frm.size() == 3) begin
                a = frm[1];
                c = frm[2];
                if (a[7:4] <= 9 && a[3:0] <= 9 && c[7:4] <= 9 && c[3:0] <= 9) begin
                    md[3] = a[7:4]; md[2] = a[3:0];
                    md[1] = c[7:4]; md[0] = c[3:0];
                end else begin
                    rep = NAK; err = 1'b1;
                end
                frm.delete();
            end
        end else begin
            rep = NAK;
            err = 1'b1;
            frm.delete();
        end
    endtask

    task automatic chk_display(input string tag);
        chk({tag, "_digits"}, {digit3, digit2, digit1, digit0},
            {md[3], md[2], md[1], md[0]});
        chk({tag, "_colon"}, colon, mcol);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        logic [7:0] er;
        logic ee;
        int pulses;
        model_byte(b, er, ee);
        @(negedge clk);
        rx_byte = b;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        strobe_cyc = cyc;
        chk("tx_ready", tx_ready, 1);
        chk("tx", tx, er);
        chk("frame_err", frame_err, ee);
        chk_display("byte");
        pulses = 0;
        for (int i = 1; i < hold; i++) begin
            @(posedge clk);
            #1;
            pulses += int'(tx_ready);
        end
        @(negedge clk);
        rx_ready = 1'b0;
        @(posedge clk);
        #1;
        pulses += int'(tx_ready);
        chk("extra_tx_ready", pulses, 0);
    endtask

    task automatic idle(input int n);
        int errs, rdys, first;
        logic exp_to;
        errs = 0;
        rdys = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (frame_err) begin
                errs++;
                if (first < 0) first = cyc - strobe_cyc;
            end
            rdys += int'(tx_ready);
        end
        exp_to = (frm.size() != 0) && (cyc - strobe_cyc >= T);
        chk("timeout_err_count", errs, int'(exp_to));
        chk("timeout_no_tx", rdys, 0);
        if (exp_to) begin
            chk("timeout_latency", first, T);
            frm.delete();
        end
        chk_display("idle");
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx"}, tx, 0);
        chk({tag, "_tx_ready"}, tx_ready, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_digits"}, {digit3, digit2, digit1, digit0}, 0);
        chk({tag, "_colon"}, colon, 3);
    endtask

    function automatic logic [7:0] gen_byte();
        logic [7:0] ops [8];
        int r;
        ops = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h30, 8'h40};
        r = $urandom_range(0, 9);
        if (r < 5) return ops[$urandom_range(0, 7)];
        if (r < 9) return {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
        return 8'($urandom);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // SET_DIGIT 2
        send_byte(8'h12, 1);
        send_byte(8'h07, 1);
        chk("t1_digit2", digit2, 7);

        // SET_ALL valid, then invalid
        send_byte(8'h20, 1);
        send_byte(8'h12, 2);
        send_byte(8'h34, 1);
        send_byte(8'h20, 1);
        send_byte(8'h1A, 1);
        send_byte(8'h00, 1);

        // READ back 1234
        send_byte(8'h40, 1);
        send_byte(8'h00, 1);

        // SET_COLON abandoned by timeout, then unknown opcode
        send_byte(8'h30, 1);
        idle(T + 5);
        chk("t5_colon", colon, 3);
        send_byte(8'h77, 1);

        // Long rx_ready level yields one reply
        send_byte(8'h00, 10);

        // Reset between ARG1 and ARG2
        send_byte(8'h20, 1);
        send_byte(8'h56, 1);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("midreset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        send_byte(8'h78, 1);

        // Random stream
        for (int k = 0; k < 300; k++) begin
            int r;
            r = $urandom_range(0, 29);
            if (r == 0) idle(T + 3);
            else if (r < 4) idle($urandom_range(1, 3));
            send_byte(gen_byte(), $urandom_range(1, 4));
        end
        idle(T + 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
